mcpu_core_irqctl: RTL and testbench

Interrupt controller directly upstream of the core coprocessor. Latches four interrupt sources (external lines plus an optional internal timer), applies a software mask, and raises a single interrupt request to the exception logic. It reports the selected cause one-hot on `int_type`, which the coprocessor records into its cause register. On the cycle the exception is taken, it clears the accepted source's pending bit.

---
 rtl/mcpu_core_irqctl.sv | 143 ++++++++++++++
 tb/tb_mcpu_core_irqctl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_core_irqctl.sv
// mcpu_core_irqctl: edge-latched, maskable four-source interrupt controller with a small register port.
// Define MCPU_IRQCTL_TIMER_EN to build the prescaled compare timer that drives source 0.
module mcpu_core_irqctl #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clkrst_core_clk,
    input  logic        clkrst_core_rst_n,
    input  logic [3:0]  irq_in,
    input  logic        interrupts_enabled,
    input  logic        int_ack,
    input  logic        reg_we,
    input  logic [1:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        int_req,
    output logic [3:0]  int_type
);

    typedef enum logic [1:0] {
        REG_MASK      = 2'd0,
        REG_PENDING   = 2'd1,
        REG_TIMER_CNT = 2'd2,
        REG_TIMER_CMP = 2'd3
    } reg_sel_e;

    logic [3:0]  r_irq_q;
    logic [3:0]  r_pending;
    logic [3:0]  r_mask;
    logic [31:0] r_rdata;

    reg_sel_e    w_reg_sel;
    logic [3:0]  w_eligible;
    logic [3:0]  w_lowest;
    logic [3:0]  w_set;
    logic [3:0]  w_ack_clr;
    logic [3:0]  w_w1c_clr;
    logic [3:0]  w_pending_nxt;
    logic [31:0] w_rdata_nxt;
    logic [31:0] w_timer_cnt_rd;
    logic [31:0] w_timer_cmp_rd;
    logic        w_mask_we;
    logic        w_pend_we;

    assign w_reg_sel = reg_sel_e'(reg_addr);
    assign w_mask_we = reg_we && (w_reg_sel == REG_MASK);
    assign w_pend_we = reg_we && (w_reg_sel == REG_PENDING);

    // Lowest set bit isolated with the two's-complement trick: x & -x.
    assign w_eligible = r_pending & r_mask;
    assign w_lowest   = w_eligible & (~w_eligible + 4'd1);
    assign int_req    = interrupts_enabled & (|w_eligible);
    assign int_type   = interrupts_enabled ? w_lowest : '0;

    assign w_ack_clr = (int_ack && int_req) ? int_type : '0;
    assign w_w1c_clr = w_pend_we ? reg_wdata[3:0] : '0;

`ifdef MCPU_IRQCTL_TIMER_EN
    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [31:0] r_timer_cnt;
    logic [31:0] r_timer_cmp;
    logic [15:0] r_pre_cnt;
    logic        w_timer_run;
    logic        w_tick;
    logic        w_timer_evt;
    logic        w_unused_irq0;

    assign w_timer_run = (r_timer_cmp != '0);
    assign w_tick      = w_timer_run && (r_pre_cnt == PRE_LAST);
    assign w_timer_evt = w_tick && (r_timer_cnt == r_timer_cmp);

    // The timer owns source 0; the external line 0 is not looked at.
    assign w_set         = {irq_in[3:1] & ~r_irq_q[3:1], w_timer_evt};
    assign w_unused_irq0 = irq_in[0];

    // A TIMER_CNT write overrides the advance, but the match above used the old count.
    always_ff @(posedge clkrst_core_clk) begin
        if (!clkrst_core_rst_n) begin
            r_timer_cnt <= '0;
            r_timer_cmp <= '0;
            r_pre_cnt   <= '0;
        end else begin
            if (w_timer_run) begin
                if (w_tick) begin
                    r_pre_cnt   <= '0;
                    r_timer_cnt <= w_timer_evt ? '0 : r_timer_cnt + 32'd1;
                end else begin
                    r_pre_cnt <= r_pre_cnt + 16'd1;
                end
            end
            if (reg_we && (w_reg_sel == REG_TIMER_CNT)) begin
                r_timer_cnt <= reg_wdata;
                r_pre_cnt   <= '0;
            end
            if (reg_we && (w_reg_sel == REG_TIMER_CMP)) begin
                r_timer_cmp <= reg_wdata;
            end
        end
    end

    assign w_timer_cnt_rd = r_timer_cnt;
    assign w_timer_cmp_rd = r_timer_cmp;
`else
    logic w_unused_cfg;

    assign w_set          = irq_in & ~r_irq_q;
    assign w_timer_cnt_rd = '0;
    assign w_timer_cmp_rd = '0;
    assign w_unused_cfg   = ^{reg_wdata[31:4], 32'(PRESCALE)};
`endif

    // New edges are ORed in after clears so a source arriving on an ack/W1C cycle survives.
    assign w_pending_nxt = (r_pending & ~(w_ack_clr | w_w1c_clr)) | w_set;

    always_comb begin
        w_rdata_nxt = '0;
        unique case (w_reg_sel)
            REG_MASK:      w_rdata_nxt = {28'd0, r_mask};
            REG_PENDING:   w_rdata_nxt = {28'd0, r_pending};
            REG_TIMER_CNT: w_rdata_nxt = w_timer_cnt_rd;
            REG_TIMER_CMP: w_rdata_nxt = w_timer_cmp_rd;
        endcase
    end

    always_ff @(posedge clkrst_core_clk) begin
        if (!clkrst_core_rst_n) begin
            r_irq_q   <= '0;
            r_pending <= '0;
            r_mask    <= '0;
            r_rdata   <= '0;
        end else begin
            r_irq_q   <= irq_in;
            r_pending <= w_pending_nxt;
            r_rdata   <= w_rdata_nxt;
            if (w_mask_we) begin
                r_mask <= reg_wdata[3:0];
            end
        end
    end

    assign reg_rdata = r_rdata;

endmodule

// File: tb/tb_mcpu_core_irqctl.sv
// Self-checking bench for mcpu_core_irqctl: directed vector table, timer sequences, then random
// stimulus against a cycle-level behavioural model.
module tb_mcpu_core_irqctl;

    localparam int unsigned TB_PRESCALE = 2;
`ifdef MCPU_IRQCTL_TIMER_EN
    localparam bit HAS_TIMER = 1'b1;
`else
    localparam bit HAS_TIMER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  irq_in = '0;
    logic        interrupts_enabled = 1'b0;
    logic        int_ack = 1'b0;
    logic        reg_we = 1'b0;
    logic [1:0]  reg_addr = '0;
    logic [31:0] reg_wdata = '0;
    logic [31:0] reg_rdata;
    logic        int_req;
    logic [3:0]  int_type;

    always #5 clk = ~clk;

    mcpu_core_irqctl #(.PRESCALE(TB_PRESCALE)) dut (
        .clkrst_core_clk    (clk),
        .clkrst_core_rst_n  (rst_n),
        .irq_in             (irq_in),
        .interrupts_enabled (interrupts_enabled),
        .int_ack            (int_ack),
        .reg_we             (reg_we),
        .reg_addr           (reg_addr),
        .reg_wdata          (reg_wdata),
        .reg_rdata          (reg_rdata),
        .int_req            (int_req),
        .int_type           (int_type)
    );

    typedef struct {
        bit          rn;
        logic [3:0]  irq;
        bit          en;
        bit          ack;
        bit          we;
        logic [1:0]  addr;
        logic [31:0] wd;
        bit          chk;
        logic        req;
        logic [3:0]  typ;
        bit          chk_rd;
        logic [31:0] rd;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [3:0]  m_q, m_pend, m_mask;
    logic [31:0] m_cnt, m_cmp, m_rdata;
    int unsigned m_pre;
    bit          m_rdv = 1'b0;

    vec_t tbl[$];

    function automatic vec_t mk(bit rn, logic [3:0] irq, bit en, bit ack, bit we, logic [1:0] addr,
                                logic [31:0] wd, bit chk, logic req, logic [3:0] typ,
                                bit chk_rd, logic [31:0] rd);
        vec_t v;
        v.rn = rn; v.irq = irq; v.en = en; v.ack = ack; v.we = we; v.addr = addr; v.wd = wd;
        v.chk = chk; v.req = req; v.typ = typ; v.chk_rd = chk_rd; v.rd = rd;
        return v;
    endfunction

    function automatic vec_t mkm(logic [3:0] irq, bit en, bit ack, bit we, logic [1:0] addr,
                                 logic [31:0] wd);
        return mk(1'b1, irq, en, ack, we, addr, wd, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] m_type(input bit en);
        logic [3:0] elig;
        elig = m_pend & m_mask;
        if (!en) return 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (elig[i]) return 4'(1 << i);
        end
        return 4'd0;
    endfunction

    function automatic logic m_req(input bit en);
        return en && ((m_pend & m_mask) != 4'd0);
    endfunction

    task automatic model_step(input vec_t v);
        logic [3:0]  typ, clr, edges;
        logic        req;
        bit          evt;
        logic [31:0] cnt_n;
        int unsigned pre_n;
        m_rdv = 1'b1;
        if (!v.rn) begin
            m_q = '0; m_pend = '0; m_mask = '0; m_cnt = '0; m_cmp = '0; m_pre = 0; m_rdata = '0;
            return;
        end
        typ = m_type(v.en);
        req = m_req(v.en);
        case (v.addr)
            2'd0:    m_rdata = {28'd0, m_mask};
            2'd1:    m_rdata = {28'd0, m_pend};
            2'd2:    m_rdata = HAS_TIMER ? m_cnt : 32'd0;
            default: m_rdata = HAS_TIMER ? m_cmp : 32'd0;
        endcase
        evt = 1'b0; cnt_n = m_cnt; pre_n = m_pre;
        if (HAS_TIMER && m_cmp != 32'd0) begin
            pre_n = (m_pre + 1) % TB_PRESCALE;
            if (pre_n == 0) begin
                if (m_cnt == m_cmp) begin
                    evt = 1'b1; cnt_n = 32'd0;
                end else begin
                    cnt_n = m_cnt + 32'd1;
                end
            end
        end
        if (HAS_TIMER && v.we && v.addr == 2'd2) begin cnt_n = v.wd; pre_n = 0; end
        if (HAS_TIMER && v.we && v.addr == 2'd3) m_cmp = v.wd;
        edges = v.irq & ~m_q;
        if (HAS_TIMER) edges[0] = evt;
        clr = 4'd0;
        if (v.ack && req) clr = clr | typ;
        if (v.we && v.addr == 2'd1) clr = clr | v.wd[3:0];
        m_pend = (m_pend & ~clr) | edges;
        if (v.we && v.addr == 2'd0) m_mask = v.wd[3:0];
        m_q = v.irq; m_cnt = cnt_n; m_pre = pre_n;
    endtask

    // Drive after the falling edge, compare 1ns later, then advance the model past the next rising edge.
    task automatic cyc(input vec_t v, input bit use_tbl, input string tag);
        @(negedge clk);
        rst_n = v.rn; irq_in = v.irq; interrupts_enabled = v.en; int_ack = v.ack;
        reg_we = v.we; reg_addr = v.addr; reg_wdata = v.wd;
        #1;
        if (use_tbl) begin
            if (v.chk) begin
                check({tag, " int_req"}, 32'(int_req), 32'(v.req));
                check({tag, " int_type"}, 32'(int_type), 32'(v.typ));
            end
            if (v.chk_rd) check({tag, " reg_rdata"}, reg_rdata, v.rd);
        end else begin
            check({tag, " int_req"}, 32'(int_req), 32'(m_req(v.en)));
            check({tag, " int_type"}, 32'(int_type), 32'(m_type(v.en)));
            if (m_rdv) check({tag, " reg_rdata"}, reg_rdata, m_rdata);
        end
        model_step(v);
    endtask

    initial begin
        int first, second, k;
        vec_t v;

        //          rn irq  en ack we addr wd            chk req typ   crd rd
        tbl.push_back(mk(0, 4'hF, 1, 0, 0, 1, 32'h0,      0, 0, 4'h0, 0, 32'h0));
        tbl.push_back(mk(0, 4'hF, 1, 0, 0, 1, 32'h0,      1, 0, 4'h0, 1, 32'h0));
        tbl.push_back(mk(1, 4'h0, 1, 0, 0, 1, 32'h0,      1, 0, 4'h0, 1, 32'h0));
        tbl.push_back(mk(1, 4'h0, 1, 0, 1, 0, 32'hC,      1, 0, 4'h0, 1, 32'h0));
        tbl.push_back(mk(1, 4'hC, 1, 0, 0, 0, 32'h0,      1, 0, 4'h0, 1, 32'h0));
        tbl.push_back(mk(1, 4'hC, 1, 1, 0, 1, 32'h0,      1, 1, 4'h4, 1, 32'hC));
        tbl.push_back(mk(1, 4'h0, 1, 1, 0, 1, 32'h0,      1, 1, 4'h8, 1, 32'hC));
        tbl.push_back(mk(1, 4'h0, 1, 0, 0, 1, 32'h0,      1, 0, 4'h0, 1, 32'h8));
        tbl.push_back(mk(1, 4'h2, 1, 0, 1, 0, 32'h0,      1, 0, 4'h0, 1, 32'h0));
        tbl.push_back(mk(1, 4'h2, 1, 0, 0, 1, 32'h0,      1, 0, 4'h0, 1, 32'hC));
        tbl.push_back(mk(1, 4'h2, 1, 0, 1, 0, 32'h2,      1, 0, 4'h0, 1, 32'h2));
        tbl.push_back(mk(1, 4'h2, 1, 0, 0, 1, 32'h0,      1, 1, 4'h2, 1, 32'h0));
        tbl.push_back(mk(1, 4'h0, 1, 0, 1, 1, 32'h2,      1, 1, 4'h2, 1, 32'h2));
        tbl.push_back(mk(1, 4'h0, 1, 0, 0, 1, 32'h0,      1, 0, 4'h0, 1, 32'h2));
        tbl.push_back(mk(1, 4'h2, 1, 0, 0, 1, 32'h0,      1, 0, 4'h0, 1, 32'h0));
        tbl.push_back(mk(1, 4'h0, 1, 0, 0, 1, 32'h0,      1, 1, 4'h2, 1, 32'h0));
        tbl.push_back(mk(1, 4'h2, 1, 1, 0, 1, 32'h0,      1, 1, 4'h2, 1, 32'h2));
        tbl.push_back(mk(1, 4'h2, 1, 0, 0, 1, 32'h0,      1, 1, 4'h2, 1, 32'h2));
        tbl.push_back(mk(1, 4'h2, 0, 1, 0, 1, 32'h0,      1, 0, 4'h0, 1, 32'h2));
        tbl.push_back(mk(1, 4'h0, 1, 1, 0, 1, 32'h0,      1, 1, 4'h2, 1, 32'h2));
        tbl.push_back(mk(1, 4'h0, 1, 0, 0, 1, 32'h0,      1, 0, 4'h0, 1, 32'h2));
        tbl.push_back(mk(1, 4'h4, 1, 0, 1, 1, 32'hF,      1, 0, 4'h0, 1, 32'h0));
        tbl.push_back(mk(1, 4'h4, 1, 0, 0, 1, 32'h0,      1, 0, 4'h0, 1, 32'h0));
        tbl.push_back(mk(1, 4'h4, 1, 0, 0, 1, 32'h0,      1, 0, 4'h0, 1, 32'h4));
        tbl.push_back(mk(1, 4'h0, 1, 0, 1, 1, 32'hF,      1, 0, 4'h0, 1, 32'h4));
`ifndef MCPU_IRQCTL_TIMER_EN
        tbl.push_back(mk(1, 4'h0, 1, 0, 1, 3, 32'h12345,  1, 0, 4'h0, 1, 32'h4));
        tbl.push_back(mk(1, 4'h0, 1, 0, 1, 2, 32'h77,     1, 0, 4'h0, 1, 32'h0));
        tbl.push_back(mk(1, 4'h1, 1, 0, 1, 0, 32'h1,      1, 0, 4'h0, 1, 32'h0));
        tbl.push_back(mk(1, 4'h1, 1, 0, 0, 2, 32'h0,      1, 1, 4'h1, 1, 32'h2));
        tbl.push_back(mk(1, 4'h0, 1, 1, 0, 3, 32'h0,      1, 1, 4'h1, 1, 32'h0));
        tbl.push_back(mk(1, 4'h0, 1, 0, 0, 1, 32'h0,      1, 0, 4'h0, 1, 32'h0));
`endif
        for (int i = 0; i < tbl.size(); i++) cyc(tbl[i], 1'b1, $sformatf("row%0d", i));

`ifdef MCPU_IRQCTL_TIMER_EN
        cyc(mkm(4'h0, 1, 0, 1, 2'd0, 32'd1), 1'b0, "tmr_mask");
        cyc(mkm(4'h0, 1, 0, 1, 2'd3, 32'd3), 1'b0, "tmr_cmp");
        cyc(mkm(4'h0, 1, 0, 1, 2'd2, 32'd0), 1'b0, "tmr_cnt");
        first = 0; second = 0;
        for (k = 1; k <= 24; k++) begin
            cyc(mkm(4'h0, 1, 1, 0, 2'd2, 32'd0), 1'b0, "tmr_run");
            if (int_req && first == 0) first = k;
            else if (int_req && second == 0) second = k;
        end
        check("tmr_first_event_cycle", 32'(first), 32'd9);
        check("tmr_second_event_cycle", 32'(second), 32'd17);
        cyc(mkm(4'h0, 1, 1, 1, 2'd3, 32'd0), 1'b0, "tmr_freeze_wr");
        for (k = 0; k < 6; k++) cyc(mkm(4'h0, 1, 1, 0, 2'd2, 32'd0), 1'b0, "tmr_frozen");

        cyc(mkm(4'h0, 1, 0, 1, 2'd3, 32'd3), 1'b0, "wrap_cmp");
        cyc(mkm(4'h0, 1, 0, 1, 2'd2, 32'hFFFF_FFFE), 1'b0, "wrap_cnt");
        first = 0;
        for (k = 1; k <= 20; k++) begin
            cyc(mkm(4'h0, 1, 1, 0, 2'd2, 32'd0), 1'b0, "wrap_run");
            if (int_req && first == 0) first = k;
        end
        check("wrap_event_cycle", 32'(first), 32'd13);
`endif

        for (k = 0; k < 600; k++) begin
            v = mkm(4'($urandom), $urandom_range(0, 7) != 0, 1'($urandom), $urandom_range(0, 4) == 0,
                    2'($urandom), $urandom);
            v.rn = ($urandom_range(0, 99) != 0);
            if (v.addr == 2'd2) v.wd = $urandom_range(0, 7);
            if (v.addr == 2'd3) v.wd = $urandom_range(0, 5);
            cyc(v, 1'b0, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
